// File: rtl/img_stream_out.sv
// Reads the filtered frame from the image SRAM and streams it out in raster order through a 2-entry prefetch FIFO.
// Optional feature: define OUT_CHECKSUM_EN to build the running 16-bit checksum of accepted pixels.
module img_stream_out #(
    parameter int BASE_ADDR = 65536,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int AW        = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cs,
    output logic          we,
    output logic [AW-1:0] addr,
    input  logic [7:0]    dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_sof,
    output logic          out_eol,
    output logic [15:0]   checksum
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   rx;
    logic [YW-1:0]   ry;
    logic [AW-1:0]   roff;
    logic            inflight;
    logic [1:0]      tag_p1;
    logic [9:0]      fifo_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            issue;
    logic            start_acc;
    logic            last_rd;
    logic            last_pop;
    logic            rx_last;
    logic            ry_last;

    assign start_acc = start && (state == IDLE);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // Slots freed by this cycle's pop are usable immediately, which is what sustains 1 pixel/clk.
    assign issue = (state == RUN) &&
                   ((int'(count) + int'(inflight) - int'(pop)) < 2);

    assign rx_last  = (rx == XW'(IMG_W - 1));
    assign ry_last  = (ry == YW'(IMG_H - 1));
    assign last_rd  = issue && rx_last && ry_last;
    assign last_pop = (state == DRAIN) && pop && (count == 2'd1) && !inflight;

    assign cs   = issue;
    assign we   = 1'b0;
    assign addr = issue ? (AW'(BASE_ADDR) + roff) : '0;
    assign busy = (state != IDLE);

    assign out_data = fifo_mem[rd_ptr][7:0];
    assign out_eol  = fifo_mem[rd_ptr][8];
    assign out_sof  = fifo_mem[rd_ptr][9];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_rd)  state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read counters: raster position plus a linear offset so no multiplier is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx   <= '0;
            ry   <= '0;
            roff <= '0;
        end else if (start_acc) begin
            rx   <= '0;
            ry   <= '0;
            roff <= '0;
        end else if (issue) begin
            roff <= roff + AW'(1);
            if (rx_last) begin
                rx <= '0;
                ry <= ry + YW'(1);
            end else begin
                rx <= rx + XW'(1);
            end
        end
    end

    // Stage p1: read in flight; tags travel with it to the FIFO write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            tag_p1   <= 2'b00;
            done     <= 1'b0;
        end else begin
            inflight <= issue;
            tag_p1   <= {issue && (rx == '0) && (ry == '0), issue && rx_last};
            done     <= last_pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_p1, dout};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    property p_no_overflow;
        @(posedge clk) disable iff (reset) !(push && !pop && (count == 2'd2));
    endproperty
    assert property (p_no_overflow);

`ifdef OUT_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          csum <= 16'd0;
        else if (start_acc) csum <= 16'd0;
        else if (pop)       csum <= csum + {8'd0, out_data};
    end

    assign checksum = csum;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_img_stream_out.sv
// Randomized bench for img_stream_out on a reduced 16x8 frame with an SRAM model and a raster-order reference.
module tb_img_stream_out;

    localparam int BASE = 65536;
    localparam int W    = 16;
    localparam int H    = 8;
    localparam int AW   = 17;
    localparam int N    = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    dout;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_sof;
    logic          out_eol;
    logic [15:0]   checksum;

    logic [7:0]    sram [N];
    int            n_vec = 0;
    int            n_err = 0;
    int            rd_idx;
    int            px_idx;
    int            done_cnt;
    logic [15:0]   csum_m;
    bit            mon_en = 1'b0;
    bit            rnd_ready = 1'b0;
    bit            stalled = 1'b0;
    logic [10:0]   held;

    img_stream_out #(.BASE_ADDR(BASE), .IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cs(cs), .we(we), .addr(addr), .dout(dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        int idx;
        idx = int'(addr) - BASE;
        if (cs) dout <= (idx >= 0 && idx < N) ? sram[idx] : 8'h5A;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        rd_idx   = 0;
        px_idx   = 0;
        done_cnt = 0;
        csum_m   = 16'd0;
    endtask

    // Monitor: drives out_ready at the falling edge, then compares against the raster model.
    initial forever begin
        @(negedge clk);
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (mon_en && !reset) begin
            if (cs) begin
                chk("addr", 32'(addr), 32'(BASE + rd_idx));
                chk("no_overrun", 32'((rd_idx - px_idx - int'(out_valid && out_ready)) < 2), 32'd1);
                rd_idx++;
            end
            if (stalled)
                chk("stall_hold", {21'd0, out_valid, out_sof, out_eol, out_data}, {21'd0, held});
            if (out_valid && out_ready) begin
                if (px_idx < N) begin
                    chk("data", 32'(out_data), 32'(sram[px_idx]));
                    chk("sof", 32'(out_sof), 32'(px_idx == 0));
                    chk("eol", 32'(out_eol), 32'((px_idx % W) == (W - 1)));
                    csum_m = csum_m + 16'(out_data);
                end else begin
                    chk("extra_px", 32'(px_idx), 32'(N - 1));
                end
                px_idx++;
            end else if (!rnd_ready && px_idx > 0 && px_idx < N) begin
                chk("no_bubble", 32'(out_valid), 32'd1);
            end
            stalled = out_valid && !out_ready;
            held    = {1'b1, out_sof, out_eol, out_data};
            if (done) begin
                done_cnt++;
                chk("done_after_last", 32'(px_idx), 32'(N));
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_px(input int target);
        int t = 0;
        while (px_idx < target && t < 20 * N) begin
            @(negedge clk);
            t++;
        end
        chk("px_timeout", 32'(px_idx >= target), 32'd1);
    endtask

    task automatic finish_frame(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 20 * N) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #3;
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({name, "_pixels"}, 32'(px_idx), 32'(N));
        chk({name, "_reads"}, 32'(rd_idx), 32'(N));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done_low"}, 32'(done), 32'd0);
`ifdef OUT_CHECKSUM_EN
        chk({name, "_checksum"}, 32'(checksum), 32'(csum_m));
`else
        chk({name, "_checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", {21'd0, out_sof, out_eol, out_data}, 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        // Ramp data, ready held high, latency from start.
        for (int i = 0; i < N; i++) sram[i] = 8'(i);
        clear_model();
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_cs", 32'(cs), 32'd1);
        chk("lat_addr", 32'(addr), 32'(BASE));
        chk("lat_valid_k1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2 chk("lat_valid_k2", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("lat_valid_k3", 32'(out_valid), 32'd1);
        chk("lat_first_data", 32'(out_data), 32'(sram[0]));
        finish_frame("ramp");

        // Random data with random backpressure.
        for (int i = 0; i < N; i++) sram[i] = 8'($urandom);
        rnd_ready = 1'b1;
        clear_model();
        pulse_start();
        finish_frame("bp");

        // Extra start pulse mid-frame is ignored.
        for (int i = 0; i < N; i++) sram[i] = 8'($urandom);
        rnd_ready = 1'b0;
        clear_model();
        pulse_start();
        wait_px(N / 2);
        pulse_start();
        finish_frame("restart_ignored");

        // Reset mid-frame aborts; the next frame restarts from (0,0).
        rnd_ready = 1'b1;
        clear_model();
        pulse_start();
        wait_px(50);
        @(negedge clk);
        #3;
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_cs", 32'(cs), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        #3 chk("abort_no_done", 32'(done_cnt), 32'd0);
        pulse_start();
        finish_frame("after_abort");

        // All-0xFF frame for the checksum.
        for (int i = 0; i < N; i++) sram[i] = 8'hFF;
        clear_model();
        pulse_start();
        finish_frame("ones");
`ifdef OUT_CHECKSUM_EN
        chk("ones_sum_const", 32'(checksum), 32'(16'((N * 255) % 65536)));
`else
        chk("ones_sum_const", 32'(checksum), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
